// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Brief    : Multi-cycle ALU: single-cycle ops, shift-add MUL and restoring
//            DIV behind a valid/ready handshake. Optional macro
//            SEQ_ALU_EARLY_OUT_EN lets MUL finish once |B| is exhausted.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int DATA_PATH_WIDTH = 8,
    parameter int SHAMT_W         = $clog2(DATA_PATH_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_PATH_WIDTH-1:0] input_A,
    input  logic [DATA_PATH_WIDTH-1:0] input_B,
    input  logic [3:0]                 op,
    input  logic                       is_signed,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_PATH_WIDTH-1:0] out,
    output logic [DATA_PATH_WIDTH-1:0] out_hi,
    output logic                       LT,
    output logic                       GT,
    output logic                       EQ,
    output logic                       Z,
    output logic                       div_by_zero
);

    localparam int W  = DATA_PATH_WIDTH;
    localparam int CW = $clog2(W) + 1;

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_MOV = 4'd5;
    localparam logic [3:0] c_OP_CMP = 4'd6;
    localparam logic [3:0] c_OP_SHL = 4'd7;
    localparam logic [3:0] c_OP_SHR = 4'd8;
    localparam logic [3:0] c_OP_SRA = 4'd9;
    localparam logic [3:0] c_OP_MUL = 4'd10;
    localparam logic [3:0] c_OP_DIV = 4'd11;
    localparam logic [3:0] c_OP_INC = 4'd12;
    localparam logic [3:0] c_OP_DEC = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_mul_q, is_mul_d;
    logic            neg_lo_q, neg_lo_d;
    logic            neg_hi_q, neg_hi_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mpl_q, mpl_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W-1:0]    out_q, out_d;
    logic [W-1:0]    hi_q, hi_d;
    logic            lt_q, lt_d, gt_q, gt_d, eq_q, eq_d, z_q, z_d, dbz_q, dbz_d;

    logic [SHAMT_W-1:0] w_amt;
    logic               w_a_neg, w_b_neg;
    logic [W-1:0]       w_a_mag, w_b_mag;
    logic [W-1:0]       w_sc_out;
    logic               w_sc_lt, w_sc_gt, w_sc_eq;
    logic [2*W-1:0]     w_acc_nx, w_prod;
    logic               w_mul_last, w_mul_skip;
    logic [W:0]         w_rem_sh, w_trial;
    logic [W-1:0]       w_rem_nx, w_quo_nx, w_quo_fix, w_rem_fix;

    assign w_amt   = input_B[SHAMT_W-1:0];
    assign w_a_neg = is_signed & input_A[W-1];
    assign w_b_neg = is_signed & input_B[W-1];
    assign w_a_mag = w_a_neg ? -input_A : input_A;
    assign w_b_mag = w_b_neg ? -input_B : input_B;

    always_comb begin
        w_sc_out = '0;
        w_sc_lt  = 1'b0;
        w_sc_gt  = 1'b0;
        w_sc_eq  = 1'b0;
        case (op)
            c_OP_ADD: w_sc_out = input_A + input_B;
            c_OP_SUB: w_sc_out = input_A - input_B;
            c_OP_AND: w_sc_out = input_A & input_B;
            c_OP_OR:  w_sc_out = input_A | input_B;
            c_OP_XOR: w_sc_out = input_A ^ input_B;
            c_OP_MOV: w_sc_out = input_B;
            c_OP_CMP: begin
                if (is_signed) begin
                    w_sc_lt = $signed(input_A) < $signed(input_B);
                    w_sc_gt = $signed(input_A) > $signed(input_B);
                end else begin
                    w_sc_lt = input_A < input_B;
                    w_sc_gt = input_A > input_B;
                end
                w_sc_eq = (input_A == input_B);
            end
            c_OP_SHL: w_sc_out = input_A << w_amt;
            c_OP_SHR: w_sc_out = input_A >> w_amt;
            c_OP_SRA: w_sc_out = $signed(input_A) >>> w_amt;
            c_OP_INC: w_sc_out = input_A + W'(1);
            c_OP_DEC: w_sc_out = input_A - W'(1);
            default:  w_sc_out = '0;
        endcase
    end

    // Multiply: accumulate the left-shifting multiplicand for each set multiplier bit,
    // so the partial product always sits in its final bit position.
    assign w_acc_nx = mpl_q[0] ? (acc_q + mcand_q) : acc_q;
    assign w_prod   = neg_lo_q ? -w_acc_nx : w_acc_nx;

`ifdef SEQ_ALU_EARLY_OUT_EN
    assign w_mul_last = (cnt_q == CW'(1)) || (mpl_q[W-1:1] == '0);
    assign w_mul_skip = (w_b_mag == '0);
`else
    assign w_mul_last = (cnt_q == CW'(1));
    assign w_mul_skip = 1'b0;
`endif

    // Restoring divide: quo_q holds the unconsumed dividend bits in its top and
    // the developing quotient in its bottom.
    assign w_rem_sh  = {rem_q, quo_q[W-1]};
    assign w_trial   = w_rem_sh - {1'b0, dvs_q};
    assign w_rem_nx  = w_trial[W] ? w_rem_sh[W-1:0] : w_trial[W-1:0];
    assign w_quo_nx  = {quo_q[W-2:0], ~w_trial[W]};
    assign w_quo_fix = neg_lo_q ? -w_quo_nx : w_quo_nx;
    assign w_rem_fix = neg_hi_q ? -w_rem_nx : w_rem_nx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mpl_d    = mpl_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        out_d    = out_q;
        hi_d     = hi_q;
        lt_d     = lt_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        z_d      = z_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    lt_d     = 1'b0;
                    gt_d     = 1'b0;
                    eq_d     = 1'b0;
                    dbz_d    = 1'b0;
                    is_mul_d = (op == c_OP_MUL);
                    state_d  = S_DONE;
                    if (op == c_OP_MUL && !w_mul_skip) begin
                        state_d  = S_BUSY;
                        cnt_d    = CW'(W);
                        acc_d    = '0;
                        mcand_d  = {{W{1'b0}}, w_a_mag};
                        mpl_d    = w_b_mag;
                        neg_lo_d = w_a_neg ^ w_b_neg;
                    end else if (op == c_OP_MUL) begin
                        out_d = '0;
                        hi_d  = '0;
                        z_d   = 1'b1;
                    end else if (op == c_OP_DIV && input_B == '0) begin
                        out_d = '1;
                        hi_d  = input_A;
                        z_d   = 1'b0;
                        dbz_d = 1'b1;
                    end else if (op == c_OP_DIV) begin
                        state_d  = S_BUSY;
                        cnt_d    = CW'(W);
                        rem_d    = '0;
                        quo_d    = w_a_mag;
                        dvs_d    = w_b_mag;
                        neg_lo_d = w_a_neg ^ w_b_neg;
                        neg_hi_d = w_a_neg;
                    end else begin
                        out_d = w_sc_out;
                        hi_d  = '0;
                        lt_d  = w_sc_lt;
                        gt_d  = w_sc_gt;
                        eq_d  = w_sc_eq;
                        z_d   = (op != c_OP_CMP) && (w_sc_out == '0);
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (is_mul_q) begin
                    acc_d   = w_acc_nx;
                    mcand_d = mcand_q << 1;
                    mpl_d   = mpl_q >> 1;
                    if (w_mul_last) begin
                        out_d   = w_prod[W-1:0];
                        hi_d    = w_prod[2*W-1:W];
                        z_d     = (w_prod[W-1:0] == '0);
                        state_d = S_DONE;
                    end
                end else begin
                    rem_d = w_rem_nx;
                    quo_d = w_quo_nx;
                    if (cnt_q == CW'(1)) begin
                        out_d   = w_quo_fix;
                        hi_d    = w_rem_fix;
                        z_d     = (w_quo_fix == '0);
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mpl_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            out_q    <= '0;
            hi_q     <= '0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            z_q      <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mpl_q    <= mpl_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            out_q    <= out_d;
            hi_q     <= hi_d;
            lt_q     <= lt_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            z_q      <= z_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out         = out_q;
    assign out_hi      = hi_q;
    assign LT          = lt_q;
    assign GT          = gt_q;
    assign EQ          = eq_q;
    assign Z           = z_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle ALU, the successor to the single-cycle datapath ALU. It keeps the single-cycle arithmetic, logic, compare and shift operations and adds barrel shifts by a variable amount, iterative multiply (shift-add) and iterative divide (restoring). It sits between decode and writeback behind a valid/ready handshake so the core can stall on long operations. All results and flags are registered.

Parameters:
DATA_PATH_WIDTH, 8, operand/result width W; must be at least 4 and a power of two.
SHAMT_W, $clog2(DATA_PATH_WIDTH), width of the shift-amount field taken from input_B[SHAMT_W-1:0].

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operation request.
in_ready  output  1  block can accept a request.
input_A  input  W  operand A.
input_B  input  W  operand B, or shift amount.
op  input  4  opcode.
is_signed  input  1  0 = unsigned, 1 = two's-complement (MUL/DIV/CMP).
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
out  output  W  result: low product, or quotient.
out_hi  output  W  high product, or remainder; 0 for other ops.
LT, GT, EQ  output  1 each  compare flags; one-hot on CMP, all 0 otherwise.
Z  output  1  out == 0 (all ops except CMP, where it is 0).
div_by_zero  output  1  DIV with input_B == 0.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV (out = B), 6 CMP, 7 SHL, 8 SHR logical, 9 SRA, 10 MUL, 11 DIV, 12 INC (A+1), 13 DEC (A-1). 14 and 15 return all-zero results with 1-cycle latency.
- Reset: FSM goes to IDLE; in_ready=1; out_valid=0; out, out_hi, all flags and internal registers are 0.
- FSM:
  - IDLE: in_ready=1. On in_valid, capture operands. A single-cycle op goes to DONE. MUL or DIV goes to BUSY with iteration counter = W.
  - BUSY: in_ready=0. One bit per cycle; the counter decrements. When the counter reaches 0 the sign fix-up is applied into the result registers and the FSM goes to DONE.
  - DONE: out_valid=1; outputs stay stable until out_valid && out_ready, then the FSM returns to IDLE. in_ready=0 in DONE. There is no back-to-back acceptance in the same cycle.
- Latency from the accept edge to out_valid: 1 cycle for single-cycle ops; W+1 cycles for MUL and DIV.
- Arithmetic: ADD, SUB, INC and DEC wrap modulo 2^W; carry is discarded.
- Shifts: amount = B[SHAMT_W-1:0] and may be 0. SRA replicates the sign bit.
- MUL: 2W-bit product split as {out_hi, out}. Signed mode multiplies magnitudes and negates the 2W result if the operand signs differ.
- DIV: the quotient truncates toward zero. The remainder takes the sign of the dividend.
  - B == 0: 1-cycle latency; out = all ones; out_hi = A; div_by_zero=1.
  - Signed MIN / -1: out = MIN, out_hi = 0, no flag.
- CMP: signed or unsigned ordering per is_signed.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; the requester must hold it.
- Asserting rst_n low mid-BUSY or mid-DONE aborts the operation immediately and discards the result.

Optional Feature:
SEQ_ALU_EARLY_OUT_EN.
- Defined: MUL leaves BUSY as soon as the remaining multiplier bits are all zero, with the product shifted into its final position. Latency is then 2 + index of the highest set bit of |B|. B == 0 gives 1-cycle latency. DIV timing is unchanged.
- Undefined: fixed W+1 latency for MUL.

Test Plan:
- Reset, then ADD with W=8, A=0x7F, B=0x01 -> out_valid one cycle after accept; out=0x80; Z=0; out_hi=0.
- Unsigned MUL A=0xFF, B=0xFF -> out_valid 9 cycles after accept; {out_hi,out}=0xFE01. Signed MUL A=0xFD (-3), B=0x05 -> 0xFFF1.
- Signed DIV A=0xF9 (-7), B=0x02 -> out=0xFD, out_hi=0xFF. DIV B=0 -> out=0xFF, out_hi=A, div_by_zero=1, 1-cycle latency.
- SRA A=0x90, B=0x03 -> out=0xF2. SHR with the same operands -> out=0x12. SHL with B=0 -> out=A.
- Hold out_ready=0 for 5 cycles after a result -> outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next cycle.
- Drop rst_n low 3 cycles into a MUL -> all outputs 0 asynchronously. After release, the next op completes normally.
